// File: rtl/cnt_sched_pkg.sv
// Shared types and helpers for the cnt_load_sched round-robin counter scheduler.
// Default widths and the round-robin pick function live here.
package cnt_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_RUN_W   = 4;
  localparam int MAX_REQ     = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // Lowest offset from (last+1) wins; scanning downward lets the nearest
  // requester overwrite any farther one.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0] last, input int n);
    rr_pick_t   r;
    logic [2:0] idx;
    r = '0;
    for (int i = n; i >= 1; i--) begin
      idx = 3'((int'(last) + i) % n);
      if (req[idx]) begin
        r.valid = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sched_load_counter.sv
// Loadable up-counter shared by all requesters; load takes priority over enable.
module sched_load_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= load_val_i;
    end else if (en_i) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_load_sched.sv
// Round-robin scheduler granting one shared loadable counter to NUM_REQ agents.
// Optional feature macro SCHED_ABORT_EN: dropping req during RUN aborts the run.
module cnt_load_sched
  import cnt_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RUN_W   = DEF_RUN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] load_val_i,
  input  logic [NUM_REQ*RUN_W-1:0] run_len_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [1:0]               state_dbg
);

  localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: req_i is a level request sampled only in IDLE; gnt_o stays
  // high from LOAD through DONE and done_o pulses for exactly one cycle.
  state_t           state;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] last;
  logic [CNT_W-1:0] lat_val;
  logic [RUN_W-1:0] lat_run;
  logic [RUN_W-1:0] run_rem;
  rr_pick_t         pick;
  logic [WIN_W-1:0] pick_w;
  logic             run_hold;
  logic             cnt_load;
  logic             cnt_en;

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req_i), 3'(last), NUM_REQ);
    pick_w = WIN_W'(pick.idx);
  end

`ifdef SCHED_ABORT_EN
  assign run_hold = req_i[win];
`else
  assign run_hold = 1'b1;
`endif

  assign cnt_load  = (state == LOAD);
  assign cnt_en    = (state == RUN) && run_hold;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      win     <= '0;
      last    <= WIN_W'(NUM_REQ - 1);
      lat_val <= '0;
      lat_run <= '0;
      run_rem <= '0;
      gnt_o   <= '0;
      done_o  <= '0;
      busy_o  <= 1'b0;
    end else begin
      done_o <= '0;
      case (state)
        IDLE: begin
          if (pick.valid) begin
            state   <= LOAD;
            win     <= pick_w;
            lat_val <= load_val_i[pick_w*CNT_W +: CNT_W];
            lat_run <= run_len_i[pick_w*RUN_W +: RUN_W];
            gnt_o   <= NUM_REQ'(1) << pick_w;
            busy_o  <= 1'b1;
          end
        end
        LOAD: begin
          run_rem <= lat_run;
          if (lat_run == '0) begin
            state  <= DONE;
            done_o <= gnt_o;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          run_rem <= run_rem - 1'b1;
          if (!run_hold) begin
            // Aborted run: release without done, aborter drops to lowest priority.
            state  <= IDLE;
            last   <= win;
            gnt_o  <= '0;
            busy_o <= 1'b0;
          end else if (run_rem == RUN_W'(1)) begin
            state  <= DONE;
            done_o <= gnt_o;
          end
        end
        DONE: begin
          state  <= IDLE;
          last   <= win;
          gnt_o  <= '0;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sched_load_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (lat_val),
    .en_i       (cnt_en),
    .count_o    (count_o)
  );

endmodule
